// File: rtl/data_mem_responder.sv
// Responder for the core data-memory valid/yumi handshake: one LD/ST at a time on an
// internal 32-bit-word SRAM, fixed accept-to-response latency, response held until consumed.
module data_mem_responder #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic        req_byte_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        resp_yumi_i,
    output logic        req_yumi_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        misalign_o,
    output logic [15:0] txn_count_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic [3:0] lat_m1_lp = 4'(latency_p - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic [15:0] txn_count_q, txn_count_d;

    logic [31:0] mem_q [0:(1<<addr_width_p)-1];

    logic [addr_width_p-1:0] idx;
    logic [1:0]              lane;
    logic [31:0]             rd_word;
    logic [31:0]             rd_byte;
    logic [31:0]             wr_word;
    logic                    accept;
    logic                    mem_we;
    logic                    unused_addr;

    // Upper address bits beyond the SRAM depth alias onto the same words.
    assign idx         = req_addr_i[addr_width_p+1:2];
    assign lane        = req_addr_i[1:0];
    assign unused_addr = ^req_addr_i[31:addr_width_p+2];

    assign rd_word = mem_q[idx];
    assign rd_byte = {24'b0, rd_word[{lane, 3'b000} +: 8]};

    always_comb begin
        wr_word = req_wdata_i;
        if (req_byte_i) begin
            wr_word                       = rd_word;
            wr_word[{lane, 3'b000} +: 8]  = req_wdata_i[7:0];
        end
    end

    // Accept is suppressed while reset is held so no store can land during reset.
    assign accept     = reset && (state_q == IDLE) && req_valid_i;
    assign req_yumi_o = accept;
    assign mem_we     = accept && req_wen_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        txn_count_d = txn_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_wen_i) begin
                        rdata_d = '0;
                    end else if (req_byte_i) begin
                        rdata_d = rd_byte;
                    end else begin
                        rdata_d = rd_word;
                    end
                    if (!req_byte_i && (lane != 2'd0)) begin
                        misalign_d = 1'b1;
                    end
                    if (latency_p == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = lat_m1_lp;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_yumi_i) begin
                    txn_count_d = txn_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            txn_count_q <= txn_count_d;
        end
    end

    // SRAM contents survive reset; the write lands on the accept edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign misalign_o   = misalign_q;
    assign txn_count_o  = txn_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at latency 1, one at latency 4, both checked
// against a word-array memory model with an expected-response queue.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    logic        clk;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_wen    [2];
    logic        req_byte   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_yumi  [2];
    logic        req_yumi   [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        misalign   [2];
    logic [15:0] txn_count  [2];

    logic [31:0] ref_mem [2][DEPTH];
    logic [15:0] ref_cnt [2];
    logic        ref_mis [2];
    logic [31:0] exp_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;

    data_mem_responder #(.addr_width_p(10), .latency_p(LAT_A)) dut_a (
        .clk(clk), .reset(rst_n[0]), .req_valid_i(req_valid[0]), .req_wen_i(req_wen[0]),
        .req_byte_i(req_byte[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .resp_yumi_i(resp_yumi[0]), .req_yumi_o(req_yumi[0]), .resp_valid_o(resp_valid[0]),
        .resp_rdata_o(resp_rdata[0]), .misalign_o(misalign[0]), .txn_count_o(txn_count[0])
    );

    data_mem_responder #(.addr_width_p(10), .latency_p(LAT_B)) dut_b (
        .clk(clk), .reset(rst_n[1]), .req_valid_i(req_valid[1]), .req_wen_i(req_wen[1]),
        .req_byte_i(req_byte[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .resp_yumi_i(resp_yumi[1]), .req_yumi_o(req_yumi[1]), .resp_valid_o(resp_valid[1]),
        .resp_rdata_o(resp_rdata[1]), .misalign_o(misalign[1]), .txn_count_o(txn_count[1])
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model: memory as plain word array, byte lanes by shift/mask.
    function automatic logic [31:0] ref_access(input int u, input bit wen, input bit bw,
                                               input logic [31:0] addr, input logic [31:0] wdata);
        int          w;
        int          ln;
        logic [31:0] old;
        w   = int'((addr >> 2) % DEPTH);
        ln  = int'(addr % 4);
        old = ref_mem[u][w];
        if (!bw && ln != 0) ref_mis[u] = 1'b1;
        if (wen) begin
            if (bw) ref_mem[u][w] = (old & ~(32'hFF << (8 * ln))) | ({24'b0, wdata[7:0]} << (8 * ln));
            else    ref_mem[u][w] = wdata;
            return 32'h0;
        end
        if (bw) return (old >> (8 * ln)) & 32'hFF;
        return old;
    endfunction

    // Drive a request that must be ignored because the unit is busy.
    task automatic poke_busy(input int u);
        req_valid[u] = 1'b1;
        req_wen[u]   = 1'($urandom_range(0, 1));
        req_byte[u]  = 1'($urandom_range(0, 1));
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
    endtask

    task automatic do_reset(input int u);
        @(negedge clk);
        rst_n[u] = 1'b0; req_valid[u] = 1'b1; resp_yumi[u] = 1'b0;
        req_wen[u] = 1'b1; req_byte[u] = 1'b0; req_addr[u] = 32'h0; req_wdata[u] = 32'h0;
        #1 check("yumi_in_reset", req_yumi[u], 0);
        @(negedge clk);
        ref_cnt[u] = '0; ref_mis[u] = 1'b0;
        check("rst_valid", resp_valid[u], 0);
        check("rst_rdata", resp_rdata[u], 0);
        check("rst_misalign", misalign[u], 0);
        check("rst_count", txn_count[u], 0);
        rst_n[u] = 1'b1; req_valid[u] = 1'b0;
    endtask

    task automatic txn(input int u, input bit wen, input bit bw, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, output logic [31:0] got);
        logic [31:0] exp_r;
        logic [15:0] cnt0;
        int          lat;
        lat = (u == 0) ? LAT_A : LAT_B;
        @(negedge clk);
        req_valid[u] = 1'b1; req_wen[u] = wen; req_byte[u] = bw;
        req_addr[u] = addr; req_wdata[u] = wdata; resp_yumi[u] = 1'b0;
        #1 check("yumi_idle", req_yumi[u], 1);
        exp_q.push_back(ref_access(u, wen, bw, addr, wdata));
        cnt0 = ref_cnt[u];
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            poke_busy(u);
            #1 check("yumi_busy", req_yumi[u], 0);
            if (k < lat) check("valid_early", resp_valid[u], 0);
        end
        check("valid_on_time", resp_valid[u], 1);
        exp_r = exp_q.pop_front();
        got   = resp_rdata[u];
        check("rdata", resp_rdata[u], exp_r);
        resp_yumi[u] = (hold == 0);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            poke_busy(u);
            #1;
            check("yumi_hold", req_yumi[u], 0);
            check("valid_hold", resp_valid[u], 1);
            check("rdata_hold", resp_rdata[u], exp_r);
            check("count_hold", txn_count[u], cnt0);
            resp_yumi[u] = (h == hold);
        end
        @(negedge clk);
        resp_yumi[u] = 1'b0; req_valid[u] = 1'b0;
        ref_cnt[u] = ref_cnt[u] + 16'd1;
        #1;
        check("valid_drop", resp_valid[u], 0);
        check("txn_count", txn_count[u], ref_cnt[u]);
        check("misalign", misalign[u], ref_mis[u]);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_wen[u] = 1'b0; req_byte[u] = 1'b0;
            req_addr[u] = '0; req_wdata[u] = '0; resp_yumi[u] = 1'b0;
            ref_cnt[u] = '0; ref_mis[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        do_reset(0);
        do_reset(1);

        // Word store then load, latency 1
        txn(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, got);
        txn(0, 0, 0, 32'h10, 32'h0, 0, got);
        check("t1_lw", got, 32'hDEADBEEF);
        check("t1_count", txn_count[0], 2);

        // Byte store into lane 3, word and byte readback
        txn(0, 1, 1, 32'h13, 32'h0000005A, 0, got);
        txn(0, 0, 0, 32'h10, 32'h0, 0, got);
        check("t2_lw", got, 32'h5AADBEEF);
        txn(0, 0, 1, 32'h13, 32'h0, 0, got);
        check("t2_lb", got, 32'h0000005A);

        // Backpressure for 5 cycles
        txn(0, 0, 0, 32'h10, 32'h0, 5, got);
        check("t3_lw", got, 32'h5AADBEEF);

        // Latency 4 and address aliasing
        txn(1, 1, 0, 32'h1000, 32'hCAFEF00D, 0, got);
        txn(1, 0, 0, 32'h0, 32'h0, 2, got);
        check("t4_alias", got, 32'hCAFEF00D);

        // Misaligned word access is sticky
        txn(1, 1, 0, 32'h10, 32'h11223344, 0, got);
        txn(1, 0, 0, 32'h11, 32'h0, 0, got);
        check("t5_mis_lw", got, 32'h11223344);
        check("t5_mis_set", misalign[1], 1);
        txn(1, 0, 0, 32'h0, 32'h0, 0, got);
        check("t5_mis_sticky", misalign[1], 1);

        // Reset while waiting: store already written, no response issued
        @(negedge clk);
        req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_byte[1] = 1'b0;
        req_addr[1] = 32'h40; req_wdata[1] = 32'h0BADF00D;
        #1 check("t5_accept", req_yumi[1], 1);
        void'(ref_access(1, 1'b1, 1'b0, 32'h40, 32'h0BADF00D));
        @(negedge clk);
        poke_busy(1);
        #1 check("t5_wait_yumi", req_yumi[1], 0);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_resp", resp_valid[1], 0);
        end
        txn(1, 0, 0, 32'h40, 32'h0, 0, got);
        check("t5_kept_store", got, 32'h0BADF00D);
        txn(1, 0, 0, 32'h0, 32'h0, 0, got);
        check("t5_kept_alias", got, 32'hCAFEF00D);

        // Randomized traffic over a preloaded 16-word window with aliased upper bits
        for (int u = 0; u < 2; u++)
            for (int w = 0; w < 16; w++)
                txn(u, 1, 0, 32'(w * 4), $urandom, 0, got);
        for (int n = 0; n < 80; n++) begin
            int u;
            bit wen;
            bit bw;
            u   = n % 2;
            wen = 1'($urandom_range(0, 1));
            bw  = 1'($urandom_range(0, 1));
            a   = $urandom;
            a[11:2] = 10'($urandom_range(0, 15));
            if (!bw && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            txn(u, wen, bw, a, $urandom, $urandom_range(0, 3), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
